instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Serial program loader: receives a little-endian 16-bit word count followed by
// 4 bytes per word over a valid/ready byte stream, writes each assembled word to
// instruction memory, and holds the downstream core in reset until the load is done.
// Optional trailing checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [31:0]       dataIN,
   output logic [ADDR_W-1:0] addr,
   output logic              en,
   output logic              RW,
   output logic              core_rst,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      BYTES,
      WRITE,
`ifdef INSTR_LOADER_CHECKSUM_EN
      CHECK,
`endif
      DONE,
      ERR
   } state_t;

   localparam logic [16:0]       DEPTH_L   = 17'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t      state_q, state_d;
   logic [15:0] nwords;
   logic [15:0] wcnt;
   logic [1:0]  bcnt;
   logic        accept;
   logic [16:0] hdr_n;
   logic        restart;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]  sum;
`endif

   assign accept  = byte_valid & byte_ready;
   assign hdr_n   = {1'b0, byte_in, nwords[7:0]};
   assign restart = start & (state_q == IDLE || state_q == DONE || state_q == ERR);

   // Next-state decode; the state after the last word depends on checksum mode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE, ERR: if (start) state_d = HDR0;
         HDR0:            if (accept) state_d = HDR1;
         HDR1: begin
            if (accept) begin
               if (hdr_n == 17'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = DONE;
`endif
               end else if (hdr_n > DEPTH_L) begin
                  state_d = ERR;
               end else begin
                  state_d = BYTES;
               end
            end
         end
         BYTES:           if (accept && bcnt == 2'd3) state_d = WRITE;
         WRITE: begin
            if (wcnt + 16'd1 == nwords) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = DONE;
`endif
            end else begin
               state_d = BYTES;
            end
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         CHECK:           if (accept) state_d = (byte_in == sum) ? DONE : ERR;
`endif
         default:         state_d = IDLE;
      endcase
   end

   // State, datapath and registered outputs (outputs decoded from the next state).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         nwords     <= '0;
         wcnt       <= '0;
         bcnt       <= '0;
         addr       <= '0;
         dataIN     <= '0;
         byte_ready <= 1'b0;
         en         <= 1'b0;
         RW         <= 1'b0;
         core_rst   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         sum        <= '0;
`endif
      end else begin
         state_q <= state_d;

         if (restart) begin
            addr <= '0;
            bcnt <= '0;
            wcnt <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum  <= '0;
`endif
         end

         if (state_q == HDR0 && accept) nwords[7:0]  <= byte_in;
         if (state_q == HDR1 && accept) nwords[15:8] <= byte_in;

         if (state_q == BYTES && accept) begin
            dataIN[8*bcnt +: 8] <= byte_in;
            bcnt                <= bcnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum                 <= sum + byte_in;
`endif
         end

         if (state_q == WRITE) begin
            wcnt <= wcnt + 16'd1;
            // Hold at the top address rather than wrapping after a full-depth load.
            if (addr != LAST_ADDR) addr <= addr + 1'b1;
         end

`ifdef INSTR_LOADER_CHECKSUM_EN
         byte_ready <= (state_d == HDR0) || (state_d == HDR1) || (state_d == BYTES) ||
                       (state_d == CHECK);
`else
         byte_ready <= (state_d == HDR0) || (state_d == HDR1) || (state_d == BYTES);
`endif
         en       <= (state_d == WRITE);
         RW       <= (state_d == WRITE);
         core_rst <= (state_d != DONE);
         done     <= (state_d == DONE);
         err      <= (state_d == ERR);
      end
   end

endmodule
